// File: rtl/speed_meter.sv
// rtl/speed_meter.sv - quadrature encoder speed meter: x4 decode, gated step count, saturated magnitude
module speed_meter #(
  parameter int WINDOW = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [7:0] speed,
  output logic       dir,
  output logic       sat,
  output logic       err,
  output logic       speed_valid
);

  localparam int NW = $clog2(WINDOW) + 2;
  localparam int WW = $clog2(WINDOW);
  localparam int MW = (NW + 1 > 9) ? NW + 1 : 9;

  logic [1:0]           sync_m;
  logic [1:0]           ab_s;
  logic [1:0]           ab_p;
  logic [1:0]           prime;
  logic signed [NW-1:0] net;
  logic [WW-1:0]        wcnt;
  logic                 err_acc;

  logic signed [1:0]    step;
  logic                 illegal_now;
  logic                 terminal;
  logic signed [MW-1:0] total;
  logic [MW-1:0]        mag;
  logic                 sat_now;
  logic [7:0]           speed_now;

  // Decode only once the synchronizer holds real pin samples, so the reset value is never seen as a step.
  always_comb begin
    step        = '0;
    illegal_now = 1'b0;
    if (prime == 2'd3) begin
      case ({ab_p, ab_s})
        4'b0001, 4'b0111, 4'b1110, 4'b1000: step = 2'sb01;
        4'b0010, 4'b1011, 4'b1101, 4'b0100: step = 2'sb11;
        4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal_now = 1'b1;
        default: step = '0;
      endcase
    end
  end

  // The terminal cycle's step belongs to the window that is closing.
  always_comb begin
    terminal  = (wcnt == WW'(WINDOW - 1));
    total     = MW'(net) + MW'(step);
    mag       = total[MW-1] ? $unsigned(-total) : $unsigned(total);
    sat_now   = (mag > MW'(255));
    speed_now = sat_now ? 8'hFF : mag[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_m      <= 2'b00;
      ab_s        <= 2'b00;
      ab_p        <= 2'b00;
      prime       <= 2'd0;
      net         <= '0;
      wcnt        <= '0;
      err_acc     <= 1'b0;
      speed       <= 8'd0;
      dir         <= 1'b1;
      sat         <= 1'b0;
      err         <= 1'b0;
      speed_valid <= 1'b0;
    end else begin
      sync_m <= {enc_a, enc_b};
      ab_s   <= sync_m;
      ab_p   <= ab_s;
      if (prime != 2'd3) begin
        prime <= prime + 2'd1;
      end

      if (terminal) begin
        speed       <= speed_now;
        dir         <= ~total[MW-1];
        sat         <= sat_now;
        err         <= err_acc | illegal_now;
        speed_valid <= 1'b1;
        net         <= '0;
        err_acc     <= 1'b0;
        wcnt        <= '0;
      end else begin
        speed_valid <= 1'b0;
        net         <= net + NW'(step);
        err_acc     <= err_acc | illegal_now;
        wcnt        <= wcnt + WW'(1);
      end
    end
  end

endmodule

// File: tb/tb_speed_meter.sv
// tb/tb_speed_meter.sv - randomized self-checking bench for speed_meter against a window-level model
module tb_speed_meter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;

  logic [7:0] a_speed, b_speed;
  logic       a_dir, a_sat, a_err, a_valid;
  logic       b_dir, b_sat, b_err, b_valid;

  int checks = 0;
  int failures = 0;
  int edges = 0;
  int pos = 0;
  logic [1:0] hist[$];

  speed_meter #(.WINDOW(64)) u64 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .speed(a_speed), .dir(a_dir), .sat(a_sat), .err(a_err), .speed_valid(a_valid)
  );

  speed_meter #(.WINDOW(512)) u512 (
    .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
    .speed(b_speed), .dir(b_dir), .sat(b_sat), .err(b_err), .speed_valid(b_valid)
  );

  always #5 clk = ~clk;

  // hist[k-1] is the pin pair sampled at edge k after reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges <= 0;
      hist.delete();
    end else begin
      edges <= edges + 1;
      hist.push_back({enc_a, enc_b});
    end
  end

  function automatic logic [1:0] gcode(input int p);
    case (p & 3)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] pin_at(input int k);
    if (k < 1 || k > hist.size()) return 2'b00;
    return hist[k-1];
  endfunction

  // A pin pair sampled at edge k lands in the count at edge k+2; edges 1..3 count nothing.
  function automatic void model(input int w, input int win, output int spd,
                                output bit d, output bit s, output bit e);
    int net;
    int diff;
    int mag;
    net = 0;
    e = 1'b0;
    for (int m = (w - 1) * win + 1; m <= w * win; m++) begin
      if (m >= 4) begin
        diff = (gidx(pin_at(m - 2)) - gidx(pin_at(m - 3))) & 3;
        if (diff == 1) net++;
        else if (diff == 3) net--;
        else if (diff == 2) e = 1'b1;
      end
    end
    mag = (net < 0) ? -net : net;
    spd = (mag > 255) ? 255 : mag;
    d = (net >= 0);
    s = (mag > 255);
  endfunction

  task automatic tick(input logic [1:0] ab);
    @(negedge clk);
    enc_a = ab[1];
    enc_b = ab[0];
  endtask

  task automatic do_reset(input logic [1:0] ab);
    @(negedge clk);
    rst = 1'b1;
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({a_speed, a_dir, a_sat, a_err, a_valid} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_w64 got speed=%0d dir=%0b sat=%0b err=%0b valid=%0b exp 0/1/0/0/0",
               a_speed, a_dir, a_sat, a_err, a_valid);
    end
    checks++;
    if ({b_speed, b_dir, b_sat, b_err, b_valid} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_w512 got speed=%0d dir=%0b sat=%0b err=%0b valid=%0b exp 0/1/0/0/0",
               b_speed, b_dir, b_sat, b_err, b_valid);
    end
  endtask

  task automatic test_rate(input int sgn, input string name);
    int spd, w, last, nstrobe, phase;
    bit d, s, e;
    pos = $urandom_range(0, 3);
    phase = $urandom_range(0, 3);
    do_reset(gcode(pos));
    last = 0;
    nstrobe = 0;
    for (int c = 0; c < 5 * 64 + 2; c++) begin
      if (((c + phase) % 4) == 3) pos += sgn;
      tick(gcode(pos));
      if (a_valid) begin
        w = edges / 64;
        model(w, 64, spd, d, s, e);
        checks++;
        if ((edges % 64) != 0 || (last != 0 && edges - last != 64)) begin
          failures++;
          $display("FAIL %s_period got strobe at edge %0d prev %0d exp multiple of 64", name, edges, last);
        end
        checks++;
        if ({a_speed, a_dir, a_sat, a_err} !== {8'(spd), d, s, e}) begin
          failures++;
          $display("FAIL %s_model w=%0d got %0d/%0b/%0b/%0b exp %0d/%0b/%0b/%0b",
                   name, w, a_speed, a_dir, a_sat, a_err, spd, d, s, e);
        end
        if (w >= 2) begin
          checks++;
          if ({a_speed, a_dir, a_sat, a_err} !== {8'd16, (sgn > 0), 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s_steady w=%0d got speed=%0d dir=%0b sat=%0b err=%0b exp 16/%0b/0/0",
                     name, w, a_speed, a_dir, a_sat, a_err, (sgn > 0));
          end
        end
        last = edges;
        nstrobe++;
      end
    end
    checks++;
    if (nstrobe != 5) begin
      failures++;
      $display("FAIL %s_strobes got %0d exp 5", name, nstrobe);
    end
  endtask

  task automatic test_saturate();
    int spd, nstrobe;
    bit d, s, e;
    pos = 0;
    do_reset(2'b00);
    nstrobe = 0;
    for (int c = 0; c < 2 * 512 + 4; c++) begin
      pos++;
      tick(gcode(pos));
      if (b_valid) begin
        model(edges / 512, 512, spd, d, s, e);
        checks++;
        if ({b_speed, b_dir, b_sat, b_err} !== {8'd255, 1'b1, 1'b1, 1'b0} ||
            {b_speed, b_dir, b_sat, b_err} !== {8'(spd), d, s, e}) begin
          failures++;
          $display("FAIL saturate edge=%0d got %0d/%0b/%0b/%0b exp 255/1/1/0 model %0d/%0b/%0b/%0b",
                   edges, b_speed, b_dir, b_sat, b_err, spd, d, s, e);
        end
        nstrobe++;
      end
    end
    checks++;
    if (nstrobe != 2) begin
      failures++;
      $display("FAIL saturate_strobes got %0d exp 2", nstrobe);
    end
  endtask

  task automatic test_cancel();
    int spd, w;
    bit d, s, e;
    pos = 0;
    do_reset(2'b00);
    for (int c = 0; c < 3 * 64 + 2; c++) begin
      if (c >= 70 && c <= 88 && (c % 2) == 0) pos++;
      if (c >= 90 && c <= 108 && (c % 2) == 0) pos--;
      if (c == 140 || c == 145 || c == 150) pos--;
      tick(gcode(pos));
      if (a_valid && edges >= 128) begin
        w = edges / 64;
        model(w, 64, spd, d, s, e);
        checks++;
        if ((w == 2 && {a_speed, a_dir, a_sat, a_err} !== {8'd0, 1'b1, 1'b0, 1'b0}) ||
            (w == 3 && {a_speed, a_dir, a_sat, a_err} !== {8'd3, 1'b0, 1'b0, 1'b0}) ||
            {a_speed, a_dir, a_sat, a_err} !== {8'(spd), d, s, e}) begin
          failures++;
          $display("FAIL cancel w=%0d got %0d/%0b/%0b/%0b exp %0d/%0b/%0b/%0b",
                   w, a_speed, a_dir, a_sat, a_err, (w == 2) ? 0 : 3, (w == 2), 1'b0, 1'b0);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int w;
    pos = 0;
    do_reset(2'b00);
    for (int c = 0; c < 3 * 64 + 2; c++) begin
      if (c == 70 || c == 74 || c == 78 || c == 86 || c == 90) pos++;
      if (c == 82) pos += 2;
      tick(gcode(pos));
      if (a_valid && edges >= 128) begin
        w = edges / 64;
        checks++;
        if ((w == 2 && {a_speed, a_dir, a_sat, a_err} !== {8'd5, 1'b1, 1'b0, 1'b1}) ||
            (w == 3 && {a_speed, a_dir, a_sat, a_err} !== {8'd0, 1'b1, 1'b0, 1'b0})) begin
          failures++;
          $display("FAIL illegal w=%0d got %0d/%0b/%0b/%0b exp %0d/1/0/%0b",
                   w, a_speed, a_dir, a_sat, a_err, (w == 2) ? 5 : 0, (w == 2));
        end
      end
    end
  endtask

  task automatic test_reset_midwindow();
    bit seen;
    pos = 0;
    do_reset(2'b00);
    for (int c = 0; c < 94; c++) begin
      if (c == 5 || c == 10) pos++;
      tick(gcode(pos));
    end
    checks++;
    if (a_speed !== 8'd2) begin
      failures++;
      $display("FAIL pre_reset_speed got %0d exp 2", a_speed);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({a_speed, a_dir, a_sat, a_err, a_valid} !== {8'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got speed=%0d dir=%0b sat=%0b err=%0b valid=%0b exp 0/1/0/0/0",
               a_speed, a_dir, a_sat, a_err, a_valid);
    end
    do_reset(2'b11);
    seen = 1'b0;
    for (int c = 0; c < 70 && !seen; c++) begin
      tick(2'b11);
      if (a_valid) begin
        seen = 1'b1;
        checks++;
        if (edges != 64 || {a_speed, a_dir, a_sat, a_err} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
          failures++;
          $display("FAIL post_reset_window got edge=%0d %0d/%0b/%0b/%0b exp edge=64 0/1/0/0",
                   edges, a_speed, a_dir, a_sat, a_err);
        end
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL post_reset_strobe got none within 70 cycles exp one at edge 64");
    end
  endtask

  task automatic test_random();
    int spd, w, r, nstrobe;
    bit d, s, e;
    pos = $urandom_range(0, 3);
    do_reset(gcode(pos));
    nstrobe = 0;
    for (int c = 0; c < 6 * 64 + 2; c++) begin
      r = $urandom_range(0, 15);
      if (r >= 5 && r <= 9) pos++;
      else if (r >= 10 && r <= 13) pos--;
      else if (r == 14) pos += 2;
      tick(gcode(pos));
      if (a_valid) begin
        w = edges / 64;
        model(w, 64, spd, d, s, e);
        checks++;
        if ({a_speed, a_dir, a_sat, a_err} !== {8'(spd), d, s, e}) begin
          failures++;
          $display("FAIL random w=%0d got %0d/%0b/%0b/%0b exp %0d/%0b/%0b/%0b",
                   w, a_speed, a_dir, a_sat, a_err, spd, d, s, e);
        end
        nstrobe++;
      end
    end
    checks++;
    if (nstrobe != 6) begin
      failures++;
      $display("FAIL random_strobes got %0d exp 6", nstrobe);
    end
  endtask

  initial begin
    test_reset();
    test_rate(1, "forward");
    test_rate(-1, "reverse");
    test_saturate();
    test_cancel();
    test_illegal();
    test_reset_midwindow();
    test_random();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
